// File: rtl/ruler_recorder.sv
// Records improving Golomb-ruler candidates: keeps the best length seen,
// counts improvements and streams each new best ruler out mark by mark.
module ruler_recorder #(
   parameter int              NUMPOSITIONS = 5,
   parameter int              VALW         = 9,
   parameter int              NUMW         = 4,
   parameter logic [VALW-1:0] INITLIMIT    = VALW'(40)
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            globalready,
   input  logic [NUMW-1:0]                 enabled,
   input  logic [(NUMPOSITIONS+1)*VALW:1]  marks_in,
   output logic [VALW-1:0]                 limit,
   output logic                            hold,
   output logic                            leaf_done,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [VALW-1:0]                 out_data,
   output logic                            out_last,
   output logic [15:0]                     solutions
);

   localparam int IW = $clog2(NUMPOSITIONS + 1);
   localparam logic [IW-1:0] LASTIDX = IW'(NUMPOSITIONS);

   typedef enum logic [2:0] {
      IDLE, CHECK, UPDATE, STREAM, DONE
   } state_t;

   state_t          state_q;
   logic            armed_q;
   logic [VALW-1:0] lat_q  [1:NUMPOSITIONS];
   logic [VALW-1:0] best_q [1:NUMPOSITIONS];
   logic [IW-1:0]   idx_q;
   logic [VALW-1:0] limit_q;
   logic [VALW-1:0] data_q;
   logic            hold_q;
   logic            leaf_q;
   logic            valid_q;
   logic            last_q;
   logic [15:0]     sol_q;

   logic            full_w;
   logic            trig_w;
   logic [VALW-1:0] len_w;
   logic [IW-1:0]   nxt_w;
   logic            unused_m0;

   assign full_w = (enabled == NUMW'(NUMPOSITIONS + 1));
   assign trig_w = (state_q == IDLE) && armed_q && globalready && full_w;
   assign len_w  = lat_q[NUMPOSITIONS];
   assign nxt_w  = idx_q + IW'(1);
   // m[0] is always zero, so it is never stored
   assign unused_m0 = ^marks_in[(NUMPOSITIONS+1)*VALW -: VALW];

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         armed_q <= 1'b1;
         idx_q   <= '0;
         limit_q <= INITLIMIT;
         data_q  <= '0;
         hold_q  <= 1'b0;
         leaf_q  <= 1'b0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         sol_q   <= '0;
         for (int k = 1; k <= NUMPOSITIONS; k++) begin
            lat_q[k]  <= '0;
            best_q[k] <= '0;
         end
      end else begin
         leaf_q <= 1'b0;
         if (!full_w) armed_q <= 1'b1;
         unique case (state_q)
            IDLE: begin
               if (trig_w) begin
                  armed_q <= 1'b0;
                  hold_q  <= 1'b1;
                  state_q <= CHECK;
                  for (int k = 1; k <= NUMPOSITIONS; k++)
                     lat_q[k] <= marks_in[(NUMPOSITIONS+1-k)*VALW -: VALW];
               end
            end
            CHECK: begin
               if (len_w != '0 && len_w < limit_q) begin
                  state_q <= UPDATE;
               end else begin
                  state_q <= DONE;
                  leaf_q  <= 1'b1;
               end
            end
            UPDATE: begin
               limit_q <= len_w;
               if (sol_q != 16'hFFFF) sol_q <= sol_q + 16'd1;
               for (int k = 1; k <= NUMPOSITIONS; k++)
                  best_q[k] <= lat_q[k];
               // best_q lands on this edge, so beat 1 comes from the latch
               idx_q   <= IW'(1);
               data_q  <= lat_q[1];
               last_q  <= (NUMPOSITIONS == 1);
               valid_q <= 1'b1;
               state_q <= STREAM;
            end
            STREAM: begin
               if (out_ready) begin
                  if (idx_q == LASTIDX) begin
                     valid_q <= 1'b0;
                     last_q  <= 1'b0;
                     leaf_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     idx_q  <= nxt_w;
                     data_q <= best_q[nxt_w];
                     last_q <= (nxt_w == LASTIDX);
                  end
               end
            end
            DONE: begin
               hold_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               hold_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign limit     = limit_q;
   assign hold      = hold_q;
   assign leaf_done = leaf_q;
   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_last  = last_q;
   assign solutions = sol_q;

endmodule

// File: tb/tb_ruler_recorder.sv
// Bench for ruler_recorder: directed vector table, hand sequences for
// retrigger and mid-stream reset, then random rulers against a model.
module tb_ruler_recorder;

   localparam int NP = 5;
   localparam int VW = 9;

   logic               clock = 1'b0;
   logic               reset;
   logic               globalready;
   logic [3:0]         enabled;
   logic [(NP+1)*VW:1] marks_in;
   logic [VW-1:0]      limit;
   logic               hold;
   logic               leaf_done;
   logic               out_valid;
   logic               out_ready;
   logic [VW-1:0]      out_data;
   logic               out_last;
   logic [15:0]        solutions;

   ruler_recorder dut (
      .clock       (clock),
      .reset       (reset),
      .globalready (globalready),
      .enabled     (enabled),
      .marks_in    (marks_in),
      .limit       (limit),
      .hold        (hold),
      .leaf_done   (leaf_done),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_last    (out_last),
      .solutions   (solutions)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [NP:0][VW-1:0] mk;
      int sbeat;
      int slen;
      bit acc;
      int lat;
      int lim;
      int sol;
   } vec_t;

   vec_t vecs [6];
   int   n_pass  = 0;
   int   n_total = 0;
   int   mdl_lim;
   int   mdl_sol;

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic set_marks(input logic [NP:0][VW-1:0] mk);
      for (int k = 0; k <= NP; k++)
         marks_in[(NP+1-k)*VW -: VW] = mk[k];
   endtask

   task automatic eval_ruler(input string nm, input logic [NP:0][VW-1:0] mk,
                             input int sbeat, input int slen, input bit rnd,
                             output int cyc, output int nb, output int stalls);
      int st;
      bit seen;
      enabled   = 4'd5;
      out_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      set_marks(mk);
      enabled     = 4'd6;
      globalready = 1'b1;
      cyc = 0; nb = 0; stalls = 0; st = 0; seen = 1'b0;
      while (!seen && cyc < 200) begin
         @(posedge clock);
         cyc++;
         @(negedge clock);
         chk({nm, " hold"}, int'(hold), 1);
         if (leaf_done) begin
            seen = 1'b1;
            chk({nm, " valid_at_done"}, int'(out_valid), 0);
         end else if (out_valid) begin
            if (nb == sbeat - 1 && st < slen) begin
               out_ready = 1'b0;
               st++;
            end else if (rnd) begin
               out_ready = ($urandom_range(0, 3) != 0);
            end else begin
               out_ready = 1'b1;
            end
            if (nb < NP) begin
               chk({nm, " data"}, int'(out_data), int'(mk[nb+1]));
               chk({nm, " last"}, int'(out_last), (nb == NP - 1) ? 1 : 0);
            end
            if (out_ready) nb++;
            else stalls++;
         end
      end
      chk({nm, " leaf_done_seen"}, int'(seen), 1);
      enabled   = 4'd5;
      out_ready = 1'b1;
   endtask

   initial begin
      int cyc, nb, stalls, cnt;
      logic [NP:0][VW-1:0] mk;
      bit acc;

      vecs[0] = '{mk: {9'd17, 9'd12, 9'd10, 9'd4, 9'd1, 9'd0},
                  sbeat: 0, slen: 0, acc: 1, lat: 8,  lim: 17, sol: 1};
      vecs[1] = '{mk: {9'd18, 9'd13, 9'd10, 9'd4, 9'd1, 9'd0},
                  sbeat: 0, slen: 0, acc: 0, lat: 2,  lim: 17, sol: 1};
      vecs[2] = '{mk: {9'd16, 9'd11, 9'd9, 9'd4, 9'd1, 9'd0},
                  sbeat: 2, slen: 3, acc: 1, lat: 11, lim: 16, sol: 2};
      vecs[3] = '{mk: {9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0},
                  sbeat: 0, slen: 0, acc: 0, lat: 2,  lim: 16, sol: 2};
      vecs[4] = '{mk: {9'd16, 9'd11, 9'd9, 9'd4, 9'd1, 9'd0},
                  sbeat: 0, slen: 0, acc: 0, lat: 2,  lim: 16, sol: 2};
      vecs[5] = '{mk: {9'd15, 9'd12, 9'd7, 9'd3, 9'd1, 9'd0},
                  sbeat: 0, slen: 0, acc: 1, lat: 8,  lim: 15, sol: 3};

      reset       = 1'b1;
      globalready = 1'b0;
      enabled     = 4'd5;
      out_ready   = 1'b1;
      marks_in    = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;

      chk("rst limit", int'(limit), 40);
      chk("rst solutions", int'(solutions), 0);
      chk("rst hold", int'(hold), 0);
      chk("rst out_valid", int'(out_valid), 0);
      chk("rst leaf_done", int'(leaf_done), 0);
      chk("rst out_last", int'(out_last), 0);
      chk("rst out_data", int'(out_data), 0);

      for (int i = 0; i < 6; i++) begin
         eval_ruler($sformatf("vec%0d", i), vecs[i].mk, vecs[i].sbeat,
                    vecs[i].slen, 1'b0, cyc, nb, stalls);
         chk($sformatf("vec%0d latency", i), cyc, vecs[i].lat);
         chk($sformatf("vec%0d beats", i), nb, vecs[i].acc ? NP : 0);
         chk($sformatf("vec%0d limit", i), int'(limit), vecs[i].lim);
         chk($sformatf("vec%0d solutions", i), int'(solutions), vecs[i].sol);
      end

      // enabled held high must not retrigger until it drops once
      enabled = 4'd5;
      @(posedge clock);
      @(negedge clock);
      set_marks({9'd14, 9'd11, 9'd7, 9'd3, 9'd1, 9'd0});
      enabled = 4'd6;
      cnt = 0;
      repeat (20) begin
         @(posedge clock);
         @(negedge clock);
         if (leaf_done) cnt++;
      end
      chk("retrig first_count", cnt, 1);
      chk("retrig limit", int'(limit), 14);
      chk("retrig solutions", int'(solutions), 4);
      enabled = 4'd5;
      @(posedge clock);
      @(negedge clock);
      enabled = 4'd6;
      cnt = 0;
      repeat (20) begin
         @(posedge clock);
         @(negedge clock);
         if (leaf_done) cnt++;
      end
      chk("retrig second_count", cnt, 1);
      chk("retrig limit2", int'(limit), 14);
      chk("retrig solutions2", int'(solutions), 4);
      enabled = 4'd5;
      @(posedge clock);
      @(negedge clock);

      // reset after two accepted beats
      set_marks({9'd12, 9'd7, 9'd4, 9'd2, 9'd1, 9'd0});
      enabled = 4'd6;
      nb  = 0;
      cyc = 0;
      while (nb < 2 && cyc < 50) begin
         @(posedge clock);
         cyc++;
         @(negedge clock);
         if (out_valid && out_ready) nb++;
      end
      chk("midrst two_beats", nb, 2);
      @(posedge clock);
      @(negedge clock);
      reset       = 1'b1;
      enabled     = 4'd5;
      globalready = 1'b0;
      @(posedge clock);
      @(negedge clock);
      chk("midrst limit", int'(limit), 40);
      chk("midrst out_valid", int'(out_valid), 0);
      chk("midrst hold", int'(hold), 0);
      chk("midrst solutions", int'(solutions), 0);
      reset = 1'b0;
      cnt = 0;
      repeat (10) begin
         @(posedge clock);
         @(negedge clock);
         if (out_valid) cnt++;
      end
      chk("midrst no_beats", cnt, 0);
      globalready = 1'b1;

      // random rulers against a length/limit model
      mdl_lim = 40;
      mdl_sol = 0;
      for (int it = 0; it < 60; it++) begin
         mk[0] = '0;
         for (int k = 1; k <= NP; k++)
            mk[k] = mk[k-1] + VW'($urandom_range(1, 6));
         if ($urandom_range(0, 7) == 0) mk = '0;
         acc = (mk[NP] != 0) && (int'(mk[NP]) < mdl_lim);
         if (acc) begin
            mdl_lim = int'(mk[NP]);
            mdl_sol++;
         end
         eval_ruler($sformatf("rnd%0d", it), mk, 0, 0, 1'b1, cyc, nb, stalls);
         chk($sformatf("rnd%0d latency", it), cyc, acc ? 3 + NP + stalls : 2);
         chk($sformatf("rnd%0d beats", it), nb, acc ? NP : 0);
         chk($sformatf("rnd%0d limit", it), int'(limit), mdl_lim);
         chk($sformatf("rnd%0d solutions", it), int'(solutions), mdl_sol);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ruler_recorder.md
RULER_RECORDER -- requirements
Module: ruler_recorder

Interface
REQ-001 Parameter NUMPOSITIONS, default 5, index of the last mark; the ruler has marks m[0]..m[NUMPOSITIONS] and m[0] is 0.
REQ-002 Parameter VALW, default 9, width of one mark position value.
REQ-003 Parameter NUMW, default 4, width of a mark-level number.
REQ-004 Parameter INITLIMIT, default 9'd40, limit value loaded at reset.
REQ-005 Port clock  input  1  single clock; all state changes on its rising edge.
REQ-006 Port reset  input  1  synchronous, active-high reset.
REQ-007 Port globalready  input  1  assembly-wide ready; the recorder acts only when it is high.
REQ-008 Port enabled  input  NUMW  currently active level; the value NUMPOSITIONS+1 means a complete ruler was accepted by the last mark.
REQ-009 Port marks_in  input  (NUMPOSITIONS+1)*VALW  packed marks, bit range [(NUMPOSITIONS+1)*VALW:1], m[0] in the most significant slice.
REQ-010 Port limit  output  VALW  current best length; mark counters keep their values strictly below it.
REQ-011 Port hold  output  1  high while the recorder is not IDLE; the assembly gates globalready with it.
REQ-012 Port leaf_done  output  1  one-cycle pulse when processing finishes; the assembly then sets enabled to NUMPOSITIONS.
REQ-013 Port out_valid  output  1  a stream beat is valid.
REQ-014 Port out_ready  input  1  the consumer accepts the beat.
REQ-015 Port out_data  output  VALW  the mark value carried by the current beat.
REQ-016 Port out_last  output  1  the current beat carries m[NUMPOSITIONS].
REQ-017 Port solutions  output  16  count of improved rulers, saturating.

Function
REQ-018 The recorder SHALL use the states IDLE, CHECK, UPDATE, STREAM and DONE.
REQ-019 An internal armed flag SHALL be set in any cycle where enabled != NUMPOSITIONS+1.
REQ-020 The recorder SHALL leave IDLE for CHECK only when armed, globalready and enabled == NUMPOSITIONS+1 are all true; on that edge it SHALL clear armed and latch all marks.
REQ-021 In CHECK, the recorder SHALL compare len = latched m[NUMPOSITIONS] against limit.
REQ-022 If len != 0 and len < limit, CHECK SHALL go to UPDATE; otherwise CHECK SHALL go to DONE, leaving limit and solutions unchanged.
REQ-023 UPDATE SHALL last one cycle, in which limit <= len, solutions increments (saturating at 16'hFFFF), and the latched marks become the best ruler; it SHALL then go to STREAM.
REQ-024 STREAM SHALL emit the best ruler m[1]..m[NUMPOSITIONS] in order, one beat per out_valid && out_ready cycle, with out_last high only on m[NUMPOSITIONS].
REQ-025 While out_ready is low, out_data and out_last SHALL remain stable.
REQ-026 After the out_last beat is accepted, out_valid SHALL drop in the next cycle and the state SHALL become DONE.
REQ-027 DONE SHALL last one cycle, assert leaf_done for that cycle only, and then return to IDLE.
REQ-028 hold SHALL be high in CHECK, UPDATE, STREAM and DONE, and low in IDLE.
REQ-029 The limit output SHALL change only in UPDATE and at reset.
REQ-030 A trigger SHALL be ignored while not IDLE; enabled held at NUMPOSITIONS+1 across DONE SHALL NOT retrigger until armed has been set again.
REQ-031 Latency from the trigger edge to leaf_done SHALL be 2 cycles for a rejected ruler, and 3 + NUMPOSITIONS cycles + stall cycles for an improving ruler.

Reset
REQ-032 reset SHALL take priority over every other input in every state, including mid-STREAM.
REQ-033 On reset, the recorder SHALL set state IDLE and limit=INITLIMIT.
REQ-034 On reset, the recorder SHALL clear solutions, out_valid, out_last, out_data, hold and leaf_done to 0.
REQ-035 On reset, the recorder SHALL clear the best ruler to 0 and set armed=1.
REQ-036 Any stream aborted by reset SHALL NOT resume after reset.

Verification
REQ-037 Improve: after reset, apply marks 0,1,4,10,12,17 with enabled=6, globalready=1, out_ready=1 -> limit=17, solutions=1, beats 1,4,10,12,17 with out_last on 17, leaf_done 8 cycles after the trigger.
REQ-038 Reject: with limit=17, apply a ruler of length 18 -> no beats, limit stays 17, leaf_done 2 cycles after the trigger.
REQ-039 Backpressure: hold out_ready low for 3 cycles during beat m[2] -> out_data stays 4 throughout, and leaf_done is delayed by 3 cycles.
REQ-040 No retrigger: hold enabled=6 for 20 cycles -> exactly one leaf_done; drop enabled to 5 for 1 cycle and then return it to 6 -> a second evaluation occurs.
REQ-041 Reset mid-stream: assert reset after 2 accepted beats -> limit=40, out_valid=0, hold=0 in the next cycle, and no further beats.
REQ-042 Length zero: apply marks all 0 with enabled=6 -> reject path, limit unchanged.
